// File: rtl/ddram_wr_merge.sv
// ddram_wr_merge: write-combining buffer between the rotation frame-buffer
// writer and the DDRAM Avalon write port. Consecutive half-word writes to the
// same 64-bit word are merged in a holding register, the merged word is queued
// in a FIFO, and the FIFO head is presented to DDRAM through a registered
// output stage that honours DDRAM_BUSY.
//
// Handshake: a beat is transferred at a rising edge where DDRAM_WE is high and
// DDRAM_BUSY is low; while DDRAM_BUSY is high the head (ADDR/DIN/BE) is held.
module ddram_wr_merge #(
   parameter int DEPTH = 16,
   parameter int HOLD  = 8
) (
   input  logic                       clk_video,
   input  logic                       rst,
   input  logic                       in_we,
   input  logic [28:0]                in_addr,
   input  logic [63:0]                in_din,
   input  logic [7:0]                 in_be,
   input  logic                       flush,
   input  logic                       DDRAM_BUSY,
   output logic [28:0]                DDRAM_ADDR,
   output logic [63:0]                DDRAM_DIN,
   output logic [7:0]                 DDRAM_BE,
   output logic                       DDRAM_WE,
   output logic [7:0]                 DDRAM_BURSTCNT,
   output logic                       DDRAM_RD,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       ovf
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            EW      = 29 + 64 + 8;
   localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
   localparam logic [7:0]    HOLD_C  = HOLD[7:0];

   // Merge register
   logic [28:0] m_addr_q, m_addr_d;
   logic [63:0] m_din_q, m_din_d;
   logic [7:0]  m_be_q, m_be_d;
   logic        mv_q, mv_d;
   logic [7:0]  idle_cnt_q, idle_cnt_d;
   // flush is registered so that, like the other push causes, it acts on state
   // captured at the previous edge
   logic        flush_q, flush_d;
   logic        ovf_q, ovf_d;

   // FIFO storage; the output stage holds the head, mem holds the rest
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   mem_cnt_q, mem_cnt_d;

   // Registered head shown on the DDRAM port
   logic          out_valid_q, out_valid_d;
   logic [28:0]   out_addr_q, out_addr_d;
   logic [63:0]   out_din_q, out_din_d;
   logic [7:0]    out_be_q, out_be_d;

   logic          push, pop, accept, mem_rd;
   logic [AW:0]   level_w;
   logic [EW-1:0] head_entry;

   // Push/pop decisions from registered state
   always_comb begin
      push    = mv_q && ((in_we && (in_addr != m_addr_q)) || (m_be_q == 8'hFF) ||
                         (idle_cnt_q == HOLD_C) || flush_q);
      pop     = out_valid_q && !DDRAM_BUSY;
      level_w = mem_cnt_q + {{AW{1'b0}}, out_valid_q};
      accept  = push && ((level_w < DEPTH_C) || pop);
      // Refill the output stage when it empties or is being consumed
      mem_rd  = (mem_cnt_q != '0) && (pop || !out_valid_q);
      head_entry = mem_q[rd_ptr_q];
   end

   // Merge register, idle counter, flush capture and sticky overflow
   always_comb begin
      m_addr_d   = m_addr_q;
      m_din_d    = m_din_q;
      m_be_d     = m_be_q;
      mv_d       = mv_q;
      idle_cnt_d = idle_cnt_q;
      flush_d    = flush;
      ovf_d      = ovf_q | (push && !accept);

      if (push && in_we) begin
         m_addr_d = in_addr;
         m_din_d  = in_din;
         m_be_d   = in_be;
         mv_d     = 1'b1;
      end else if (push) begin
         mv_d     = 1'b0;
      end else if (in_we && mv_q) begin
         for (int i = 0; i < 8; i++) begin
            if (in_be[i]) m_din_d[i*8 +: 8] = in_din[i*8 +: 8];
         end
         m_be_d = m_be_q | in_be;
      end else if (in_we) begin
         m_addr_d = in_addr;
         m_din_d  = in_din;
         m_be_d   = in_be;
         mv_d     = 1'b1;
      end

      if (in_we)
         idle_cnt_d = 8'd0;
      else if (!mv_d)
         idle_cnt_d = 8'd0;
      else if (mv_q && (idle_cnt_q < HOLD_C))
         idle_cnt_d = idle_cnt_q + 8'd1;
   end

   // FIFO pointers, occupancy and output stage
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_cnt_d   = mem_cnt_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_din_d   = out_din_q;
      out_be_d    = out_be_q;

      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (mem_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && !mem_rd)
         mem_cnt_d = mem_cnt_q + 1'b1;
      else if (!accept && mem_rd)
         mem_cnt_d = mem_cnt_q - 1'b1;

      if (mem_rd) begin
         out_valid_d = 1'b1;
         out_addr_d  = head_entry[EW-1 -: 29];
         out_din_d   = head_entry[71:8];
         out_be_d    = head_entry[7:0];
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_video) begin
      if (rst) begin
         m_addr_q    <= '0;
         m_din_q     <= '0;
         m_be_q      <= '0;
         mv_q        <= 1'b0;
         idle_cnt_q  <= '0;
         flush_q     <= 1'b0;
         ovf_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_din_q   <= '0;
         out_be_q    <= '0;
      end else begin
         m_addr_q    <= m_addr_d;
         m_din_q     <= m_din_d;
         m_be_q      <= m_be_d;
         mv_q        <= mv_d;
         idle_cnt_q  <= idle_cnt_d;
         flush_q     <= flush_d;
         ovf_q       <= ovf_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_din_q   <= out_din_d;
         out_be_q    <= out_be_d;
      end
   end

   // FIFO storage write; contents need no reset since occupancy gates use
   always_ff @(posedge clk_video) begin
      if (!rst && accept) mem_q[wr_ptr_q] <= {m_addr_q, m_din_q, m_be_q};
   end

   assign DDRAM_ADDR     = out_addr_q;
   assign DDRAM_DIN      = out_din_q;
   assign DDRAM_BE       = out_be_q;
   assign DDRAM_WE       = out_valid_q;
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_RD       = 1'b0;
   assign level          = level_w;
   assign ovf            = ovf_q;

endmodule
